// File: rtl/issue_dispatch_pkg.sv
// issue_dispatch_pkg: uop field widths and offsets shared by rename, issue_dispatch and issue_slot.
package issue_dispatch_pkg;
    localparam int UOP_OP_W = 7;
    localparam int ISSUE_META_W = 3;
    function automatic int uop_width(input int wr, input int wt, input int wb);
        return UOP_OP_W + wb + wt + 3 * wr;
    endfunction
    function automatic int rs2_lo(input int wr);
        return wr;
    endfunction
    function automatic int rd_lo(input int wr);
        return 2 * wr;
    endfunction
    function automatic int brm_lo(input int wr, input int wt);
        return 3 * wr + wt;
    endfunction
endpackage

// File: rtl/issue_dispatch_busy_table.sv
// busy_table: one busy bit per physical register, read ports see same-cycle writeback clears.
module busy_table
    import issue_dispatch_pkg::*;
#(
    parameter int WIDTH_REG = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_set_en,
    input  logic [WIDTH_REG-1:0] i_set_idx,
    input  logic [WIDTH_REG-1:0] i_clr0,
    input  logic [WIDTH_REG-1:0] i_clr1,
    input  logic [WIDTH_REG-1:0] i_clr2,
    input  logic [WIDTH_REG-1:0] i_clr3,
    input  logic [WIDTH_REG-1:0] i_rs0,
    input  logic [WIDTH_REG-1:0] i_rs1,
    output logic                 o_rdy0,
    output logic                 o_rdy1
);
    localparam int N = 1 << WIDTH_REG;
    logic [N-1:0] busy, set_mask, clr_mask;
    always_comb begin
        set_mask = i_set_en ? N'(1) << i_set_idx : '0;
        clr_mask = (N'(1) << i_clr0) | (N'(1) << i_clr1) | (N'(1) << i_clr2) | (N'(1) << i_clr3);
        o_rdy0 = ~busy[i_rs0] | clr_mask[i_rs0];
        o_rdy1 = ~busy[i_rs1] | clr_mask[i_rs1];
    end
    // register 0 is hardwired ready, so its bit is masked off and never stored
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) busy <= '0;
        else busy <= ((busy & ~clr_mask) | set_mask) & ~N'(1);
    end
endmodule

// File: rtl/issue_dispatch.sv
// issue_dispatch: FIFO between rename and the issue slots; dispatches the head uop
// into the lowest free slot with operand-ready bits, draining branch-killed uops.
module issue_dispatch
    import issue_dispatch_pkg::*;
#(
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_TAG = 5,
    parameter int WIDTH_BRM = 3,
    parameter int SLOTS = 8,
    parameter int DEPTH = 4,
    localparam int WIDTH_U = uop_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM),
    localparam int WIDTH_I = WIDTH_U + ISSUE_META_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH_U-1:0]     i_uop,
    input  logic [SLOTS-1:0]       i_slot_free,
    output logic [SLOTS-1:0]       o_en,
    output logic [WIDTH_I-1:0]     o_data,
    input  logic [4*WIDTH_REG-1:0] i_WDest4x,
    input  logic [WIDTH_BRM:0]     i_BrKill
);
    localparam int AW = $clog2(DEPTH);
    localparam int BRM_LO = brm_lo(WIDTH_REG, WIDTH_TAG);
    logic [WIDTH_U-1:0] mem [DEPTH];
    logic [DEPTH-1:0] kill;
    logic [AW:0] head, tail;
    logic [WIDTH_U-1:0] head_uop;
    logic [WIDTH_BRM-1:0] kill_mask;
    logic [SLOTS-1:0] sel;
    logic full, empty, push, pop, dispatch, kill_en, head_dead, in_dead, p1, p2;
    always_comb begin
        kill_en = i_BrKill[WIDTH_BRM];
        kill_mask = i_BrKill[WIDTH_BRM-1:0];
        head_uop = mem[head[AW-1:0]];
        head_dead = kill[head[AW-1:0]] | (kill_en & |(head_uop[BRM_LO +: WIDTH_BRM] & kill_mask));
        in_dead = kill_en & |(i_uop[BRM_LO +: WIDTH_BRM] & kill_mask);
        full = head[AW-1:0] == tail[AW-1:0] && head[AW] != tail[AW];
        empty = head == tail;
        o_ready = ~full;
        push = i_valid & ~full;
        // x & -x isolates the lowest set bit
        sel = i_slot_free & (~i_slot_free + SLOTS'(1));
        dispatch = ~empty & ~head_dead & |i_slot_free;
        pop = ~empty & (head_dead | |i_slot_free);
        o_en = dispatch ? sel : '0;
        o_data = {head_uop, dispatch, p2, p1};
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head <= '0;
            tail <= '0;
            kill <= '0;
        end else begin
            if (push) tail <= tail + (AW+1)'(1);
            if (pop) head <= head + (AW+1)'(1);
            for (int i = 0; i < DEPTH; i++)
                kill[i] <= (push && tail[AW-1:0] == AW'(i)) ? in_dead
                         : kill[i] | (kill_en & |(mem[i][BRM_LO +: WIDTH_BRM] & kill_mask));
        end
    end
    always_ff @(posedge i_clk) begin
        if (push) mem[tail[AW-1:0]] <= i_uop;
    end
    busy_table #(.WIDTH_REG(WIDTH_REG)) u_busy (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_set_en (dispatch),
        .i_set_idx(head_uop[rd_lo(WIDTH_REG) +: WIDTH_REG]),
        .i_clr0   (i_WDest4x[0 +: WIDTH_REG]),
        .i_clr1   (i_WDest4x[WIDTH_REG +: WIDTH_REG]),
        .i_clr2   (i_WDest4x[2*WIDTH_REG +: WIDTH_REG]),
        .i_clr3   (i_WDest4x[3*WIDTH_REG +: WIDTH_REG]),
        .i_rs0    (head_uop[0 +: WIDTH_REG]),
        .i_rs1    (head_uop[rs2_lo(WIDTH_REG) +: WIDTH_REG]),
        .o_rdy0   (p1),
        .o_rdy1   (p2)
    );
endmodule

// File: tb/tb_issue_dispatch.sv
// tb_issue_dispatch: scoreboarded dispatch checks plus hand-timed fill, kill and reset sequences.
module tb_issue_dispatch;
    logic i_clk = 0, i_rst_n = 0, i_valid = 0, o_ready;
    logic [29:0] i_uop = '0;
    logic [7:0] i_slot_free = '0, o_en;
    logic [32:0] o_data;
    logic [19:0] i_WDest4x = '0;
    logic [3:0] i_BrKill = '0;
    int tests = 0, fails = 0;
    typedef struct {logic [7:0] en; logic [29:0] uop; logic p2; logic p1;} exp_t;
    typedef struct {logic [7:0] free; logic [7:0] en;} vec_t;
    exp_t sb[$];
    exp_t e;
    vec_t tbl[7];
    issue_dispatch dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_uop(i_uop), .i_slot_free(i_slot_free), .o_en(o_en), .o_data(o_data),
        .i_WDest4x(i_WDest4x), .i_BrKill(i_BrKill)
    );
    always #5 i_clk = ~i_clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [29:0] mk(input logic [6:0] op, input logic [2:0] brm, input logic [4:0] tag,
                                       input logic [4:0] rd, input logic [4:0] rs2, input logic [4:0] rs1);
        return {op, brm, tag, rd, rs2, rs1};
    endfunction
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask
    task automatic send(input logic [29:0] u, input logic want, input logic [7:0] en, input logic p2, input logic p1);
        if (want) sb.push_back('{en, u, p2, p1});
        i_valid = 1;
        i_uop = u;
        step();
        i_valid = 0;
    endtask
    always @(negedge i_clk) begin
        if (o_en != 0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_dispatch: got en=%0h data=%0h expected none", o_en, o_data);
            end else begin
                e = sb.pop_front();
                check("dispatch_en", 64'(o_en), 64'(e.en));
                check("dispatch_data", 64'(o_data), 64'({e.uop, 1'b1, e.p2, e.p1}));
            end
        end else check("idle_val", 64'(o_data[2]), 0);
    end
    initial begin
        tbl = '{'{8'h01, 8'h01}, '{8'hFF, 8'h01}, '{8'h80, 8'h80}, '{8'hA0, 8'h20},
                '{8'h06, 8'h02}, '{8'h48, 8'h08}, '{8'h0C, 8'h04}};
        step();
        step();
        check("rst_ready", 64'(o_ready), 1);
        check("rst_en", 64'(o_en), 0);
        check("rst_val", 64'(o_data[2]), 0);
        i_rst_n = 1;
        step();
        // first dispatch sets busy[7]; dependent reads stall, then writeback bypass
        i_slot_free = 8'hFF;
        send(mk(7'h01, 0, 1, 7, 0, 3), 1, 8'h01, 1, 1);
        send(mk(7'h02, 0, 2, 0, 0, 7), 1, 8'h01, 1, 0);
        send(mk(7'h03, 0, 3, 0, 0, 7), 1, 8'h01, 1, 1);
        i_WDest4x = 20'(7) << 10;
        step();
        i_WDest4x = '0;
        send(mk(7'h04, 0, 4, 0, 0, 7), 1, 8'h01, 1, 1);
        step();
        // set beats a same-edge clear of the same register
        send(mk(7'h05, 0, 5, 9, 0, 0), 1, 8'h01, 1, 1);
        i_WDest4x = 20'(9);
        send(mk(7'h06, 0, 6, 0, 9, 0), 1, 8'h01, 0, 1);
        i_WDest4x = '0;
        step();
        send(mk(7'h07, 0, 7, 0, 9, 0), 1, 8'h01, 1, 1);
        i_WDest4x = 20'(9) << 5;
        step();
        i_WDest4x = '0;
        step();
        for (int i = 0; i < 7; i++) begin
            i_slot_free = '0;
            send(mk(7'h40 + 7'(i), 0, 5'(i), 0, 0, 0), 1, tbl[i].en, 1, 1);
            i_slot_free = tbl[i].free;
            step();
        end
        i_slot_free = '0;
        step();
        for (int i = 0; i < 5; i++) begin
            i_valid = 1;
            i_uop = mk(7'h20 + 7'(i), 0, 5'(i), 0, 0, 0);
            #1 check("ready_fill", 64'(o_ready), (i < 4) ? 1 : 0);
            if (i < 4) sb.push_back('{8'h20, i_uop, 1'b1, 1'b1});
            step();
        end
        check("ready_full", 64'(o_ready), 0);
        i_slot_free = 8'h20;
        #1 check("no_bypass", 64'(o_ready), 0);
        step();
        check("ready_after_pop", 64'(o_ready), 1);
        sb.push_back('{8'h20, i_uop, 1'b1, 1'b1});
        step();
        i_valid = 0;
        repeat (5) step();
        i_slot_free = '0;
        send(mk(7'h30, 3'b010, 1, 0, 0, 0), 0, 0, 0, 0);
        send(mk(7'h31, 3'b001, 2, 0, 0, 0), 1, 8'h01, 1, 1);
        send(mk(7'h32, 3'b010, 3, 0, 0, 0), 0, 0, 0, 0);
        i_slot_free = 8'hFF;
        i_BrKill = 4'b1010;
        #1 check("kill_head_en", 64'(o_en), 0);
        step();
        i_BrKill = '0;
        repeat (4) step();
        i_BrKill = 4'b1100;
        send(mk(7'h33, 3'b100, 4, 0, 0, 0), 0, 0, 0, 0);
        i_BrKill = '0;
        #1 check("killed_on_push", 64'(o_en), 0);
        step();
        step();
        send(mk(7'h50, 0, 8, 12, 0, 0), 1, 8'h01, 1, 1);
        step();
        i_slot_free = '0;
        send(mk(7'h51, 0, 9, 13, 0, 12), 0, 0, 0, 0);
        send(mk(7'h52, 0, 10, 14, 0, 0), 0, 0, 0, 0);
        #2 i_rst_n = 0;
        i_slot_free = 8'hFF;
        #1 check("midrst_ready", 64'(o_ready), 1);
        check("midrst_en", 64'(o_en), 0);
        check("midrst_val", 64'(o_data[2]), 0);
        step();
        i_rst_n = 1;
        step();
        check("post_rst_en", 64'(o_en), 0);
        send(mk(7'h53, 0, 11, 0, 0, 12), 1, 8'h01, 1, 1);
        repeat (3) step();
        check("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
